// File: rtl/ball_engine.sv
// Ball position and score engine for the ball-and-paddle display.
// Motion is paced by an internal tick; serve, play, point and game-over are sequenced by a small FSM.
module ball_engine #(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int BALL        = 8,
    parameter int P1_X        = 16,
    parameter int P2_X        = 616,
    parameter int PAD_W       = 8,
    parameter int PAD_H_S     = 48,
    parameter int PAD_H_L     = 96,
    parameter int TICK_DIV    = 416667,
    parameter int SERVE_TICKS = 60,
    parameter int WIN_SCORE   = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        restart,
    input  logic        bat_size,
    input  logic [10:0] p1_y,
    input  logic [10:0] p2_y,
    output logic [10:0] bx,
    output logic [10:0] by,
    output logic [4:0]  score1,
    output logic [4:0]  score2,
    output logic        point_p1,
    output logic        point_p2,
    output logic        game_over
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;

    localparam logic [10:0] CX = 11'((H_RES - BALL) / 2);
    localparam logic [10:0] CY = 11'((V_RES - BALL) / 2);

    localparam logic [1:0] S_SERVE = 2'd0;
    localparam logic [1:0] S_PLAY  = 2'd1;
    localparam logic [1:0] S_POINT = 2'd2;
    localparam logic [1:0] S_OVER  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic [10:0]   bx_q, bx_d;
    logic [10:0]   by_q, by_d;
    logic          dx_q, dx_d;   // 1 = moving right
    logic          dy_q, dy_d;   // 1 = moving down
    logic [4:0]    score1_q, score1_d;
    logic [4:0]    score2_q, score2_d;
    logic          pp1_q, pp1_d;
    logic          pp2_q, pp2_d;
    logic          go_q, go_d;

    logic          tick;
    logic [10:0]   h_pad;
    logic [11:0]   ball_bot, ball_right, p1_bot, p2_bot;
    logic          hit1, hit2;

    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        scnt_d   = scnt_q;
        bx_d     = bx_q;
        by_d     = by_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        score1_d = score1_q;
        score2_d = score2_q;
        pp1_d    = 1'b0;
        pp2_d    = 1'b0;
        tick     = 1'b0;

        h_pad      = bat_size ? 11'(PAD_H_L) : 11'(PAD_H_S);
        ball_bot   = {1'b0, by_q} + 12'(BALL);
        ball_right = {1'b0, bx_q} + 12'(BALL);
        p1_bot     = {1'b0, p1_y} + {1'b0, h_pad};
        p2_bot     = {1'b0, p2_y} + {1'b0, h_pad};
        hit1       = (ball_bot > {1'b0, p1_y}) && ({1'b0, by_q} < p1_bot);
        hit2       = (ball_bot > {1'b0, p2_y}) && ({1'b0, by_q} < p2_bot);

        if (restart) begin
            state_d  = S_SERVE;
            tcnt_d   = '0;
            scnt_d   = '0;
            bx_d     = CX;
            by_d     = CY;
            dx_d     = 1'b1;
            dy_d     = 1'b1;
            score1_d = '0;
            score2_d = '0;
        end else if (en) begin
            if (tcnt_q == TW'(TICK_DIV - 1)) begin
                tcnt_d = '0;
                tick   = 1'b1;
            end else begin
                tcnt_d = tcnt_q + TW'(1);
            end

            if (tick) begin
                case (state_q)
                    S_SERVE: begin
                        bx_d = CX;
                        by_d = CY;
                        if (scnt_q == SW'(SERVE_TICKS - 1)) begin
                            scnt_d  = '0;
                            state_d = S_PLAY;
                        end else begin
                            scnt_d = scnt_q + SW'(1);
                        end
                    end
                    S_PLAY: begin
                        if (!dx_q && bx_q == '0) begin
                            score2_d = score2_q + 5'd1;
                            pp2_d    = 1'b1;
                            state_d  = S_POINT;
                        end else if (dx_q && ball_right == 12'(H_RES)) begin
                            score1_d = score1_q + 5'd1;
                            pp1_d    = 1'b1;
                            state_d  = S_POINT;
                        end else if (!dx_q && bx_q == 11'(P1_X + PAD_W) && hit1) begin
                            dx_d = 1'b1;
                            bx_d = bx_q + 11'd1;
                        end else if (dx_q && ball_right == 12'(P2_X) && hit2) begin
                            dx_d = 1'b0;
                            bx_d = bx_q - 11'd1;
                        end else if (dx_q) begin
                            bx_d = bx_q + 11'd1;
                        end else begin
                            bx_d = bx_q - 11'd1;
                        end

                        // Vertical motion runs independently, so corner bounces flip both axes.
                        if (!dy_q && by_q == '0) begin
                            dy_d = 1'b1;
                            by_d = 11'd1;
                        end else if (dy_q && ball_bot == 12'(V_RES)) begin
                            dy_d = 1'b0;
                            by_d = by_q - 11'd1;
                        end else if (dy_q) begin
                            by_d = by_q + 11'd1;
                        end else begin
                            by_d = by_q - 11'd1;
                        end
                    end
                    S_POINT: begin
                        bx_d = CX;
                        by_d = CY;
                        // Serve heads back toward the side that just scored.
                        dx_d = ~dx_q;
                        dy_d = ~dy_q;
                        if (score1_q == 5'(WIN_SCORE) || score2_q == 5'(WIN_SCORE)) begin
                            state_d = S_OVER;
                        end else begin
                            state_d = S_SERVE;
                        end
                    end
                    S_OVER: begin
                        bx_d = CX;
                        by_d = CY;
                    end
                    default: state_d = S_SERVE;
                endcase
            end
        end

        go_d = (state_d == S_OVER);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_SERVE;
            tcnt_q   <= '0;
            scnt_q   <= '0;
            bx_q     <= CX;
            by_q     <= CY;
            dx_q     <= 1'b1;
            dy_q     <= 1'b1;
            score1_q <= '0;
            score2_q <= '0;
            pp1_q    <= 1'b0;
            pp2_q    <= 1'b0;
            go_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            tcnt_q   <= tcnt_d;
            scnt_q   <= scnt_d;
            bx_q     <= bx_d;
            by_q     <= by_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            score1_q <= score1_d;
            score2_q <= score2_d;
            pp1_q    <= pp1_d;
            pp2_q    <= pp2_d;
            go_q     <= go_d;
        end
    end

    assign bx        = bx_q;
    assign by        = by_q;
    assign score1    = score1_q;
    assign score2    = score2_q;
    assign point_p1  = pp1_q;
    assign point_p2  = pp2_q;
    assign game_over = go_q;

endmodule
